// File: rtl/logic_stream_unit.sv
// Purpose : registered bitwise logic unit (OR/AND/XOR/NOR) with a multi-beat
//           OR/XOR accumulate mode, valid/ready on both sides.
// Latency : 1 cycle from the accepting edge to out_valid; beats that only fold
//           into a running accumulation produce no output.
// Backpr. : single output register; in_ready = !out_valid || out_ready, so a
//           stalled result freezes the accumulator, the FSM and the outputs.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand beat handshake
//   a, b [WIDTH]               operands
//   op [3]                     0 OR, 1 AND, 2 XOR, 3 NOR, 4 ACC_OR, 5 ACC_XOR,
//                              6-7 illegal
//   last                       closes an accumulate transaction
//   out_valid / out_ready      result handshake
//   y [WIDTH], y_any           result and its reduction-OR
//   y_cnt [CNT_W]              beats folded into this result (saturating)
//   err                        result came from an illegal op
module logic_stream_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic [CNT_W-1:0] y_cnt,
  output logic             err
);

  localparam logic [2:0] OP_OR      = 3'd0;
  localparam logic [2:0] OP_AND     = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NOR     = 3'd3;
  localparam logic [2:0] OP_ACC_OR  = 3'd4;
  localparam logic [2:0] OP_ACC_XOR = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Everything the output register carries travels together.
  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } res_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic             acc_xor_q,   acc_xor_d;   // 1: XOR accumulation, 0: OR
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  res_t             res_q,       res_d;

  logic             accept;
  logic             produce;
  res_t             res_new;
  logic [WIDTH-1:0] pair_or;
  logic [WIDTH-1:0] pair_xor;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign pair_or  = a | b;
  assign pair_xor = a ^ b;
  // In ACCUM the latched op decides the fold; the op input is ignored.
  assign fold     = acc_xor_q ? (acc_q ^ pair_xor) : (acc_q | pair_or);
  // Count sticks at all-ones rather than wrapping.
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_xor_d   = acc_xor_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    produce     = 1'b0;
    res_new     = '0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          case (op)
            OP_OR, OP_AND, OP_XOR, OP_NOR: begin
              produce     = 1'b1;
              res_new.cnt = CNT_W'(1);
              case (op)
                OP_OR:   res_new.y = pair_or;
                OP_AND:  res_new.y = a & b;
                OP_XOR:  res_new.y = pair_xor;
                default: res_new.y = ~pair_or;
              endcase
            end
            OP_ACC_OR, OP_ACC_XOR: begin
              if (last) begin
                // Single-beat transaction: never enters ACCUM.
                produce     = 1'b1;
                res_new.y   = (op == OP_ACC_XOR) ? pair_xor : pair_or;
                res_new.cnt = CNT_W'(1);
              end else begin
                acc_d     = (op == OP_ACC_XOR) ? pair_xor : pair_or;
                acc_xor_d = (op == OP_ACC_XOR);
                cnt_d     = CNT_W'(1);
                state_d   = ST_ACCUM;
              end
            end
            default: begin
              // Illegal op: flagged zero result, FSM untouched.
              produce     = 1'b1;
              res_new.y   = '0;
              res_new.cnt = CNT_W'(1);
              res_new.err = 1'b1;
            end
          endcase
        end
        default: begin // ST_ACCUM
          if (last) begin
            produce     = 1'b1;
            res_new.y   = fold;
            res_new.cnt = cnt_inc;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            acc_d = fold;
            cnt_d = cnt_inc;
          end
        end
      endcase
    end

    // Drain first, then a new result (if any) overrides: drain+load keeps
    // out_valid high with no bubble.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (produce) begin
      out_valid_d = 1'b1;
      res_d       = res_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      acc_xor_q   <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_xor_q   <= acc_xor_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = res_q.y;
  assign y_cnt     = res_q.cnt;
  assign err       = res_q.err;
  assign y_any     = |res_q.y;

endmodule

// File: tb/tb_logic_stream_unit.sv
// Purpose : scoreboard bench for logic_stream_unit (WIDTH=8, CNT_W=4).
// Latency : expects each result one cycle after the accepting edge.
// Backpr. : randomly deasserts out_ready; results must hold until drained.
module tb_logic_stream_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_any;
  logic [CNT_W-1:0] y_cnt;
  logic             err;

  logic_stream_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .last(last),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_any(y_any), .y_cnt(y_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    int               cnt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endfunction

  // ---------------- reference model ----------------
  // An accumulate transaction is kept as the list of its operand pairs and
  // reduced only when it closes.
  bit               in_txn;
  logic [2:0]       txn_op;
  logic [WIDTH-1:0] txn_a[$];
  logic [WIDTH-1:0] txn_b[$];

  function automatic void push_res(logic [WIDTH-1:0] ry, int rc, logic re);
    exp_t e;
    e.y = ry; e.cnt = (rc > CMAX) ? CMAX : rc; e.err = re;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    in_txn = 0;
    txn_a.delete();
    txn_b.delete();
  endfunction

  function automatic void model_accept(logic [WIDTH-1:0] pa, logic [WIDTH-1:0] pb,
                                       logic [2:0] pop, logic pl);
    logic [WIDTH-1:0] r;
    if (in_txn) begin
      txn_a.push_back(pa);
      txn_b.push_back(pb);
      if (pl) begin
        r = '0;
        for (int i = 0; i < txn_a.size(); i++)
          r = (txn_op == 3'd4) ? (r | txn_a[i] | txn_b[i]) : (r ^ txn_a[i] ^ txn_b[i]);
        push_res(r, txn_a.size(), 1'b0);
        in_txn = 0;
        txn_a.delete();
        txn_b.delete();
      end
    end else begin
      case (pop)
        3'd0: push_res(pa | pb, 1, 1'b0);
        3'd1: push_res(pa & pb, 1, 1'b0);
        3'd2: push_res(pa ^ pb, 1, 1'b0);
        3'd3: push_res(~(pa | pb), 1, 1'b0);
        3'd4, 3'd5: begin
          if (pl) push_res((pop == 3'd4) ? (pa | pb) : (pa ^ pb), 1, 1'b0);
          else begin
            in_txn = 1;
            txn_op = pop;
            txn_a.push_back(pa);
            txn_b.push_back(pb);
          end
        end
        default: push_res('0, 1, 1'b1);
      endcase
    end
  endfunction

  // ---------------- monitor ----------------
  // Samples at the falling edge; the driver registers acceptances 2 units
  // later, so the queue here holds exactly the results the DUT should show.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("y", y, e.y);
          chk("y_any", y_any, |e.y);
          chk("y_cnt", y_cnt, e.cnt);
          chk("err", err, e.err);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(bit v, logic [WIDTH-1:0] pa, logic [WIDTH-1:0] pb,
                       logic [2:0] pop, bit pl, bit ordy);
    @(posedge clk); #1;
    in_valid = v; a = pa; b = pb; op = pop; last = pl; out_ready = ordy;
    @(negedge clk); #2;
    if (in_valid && in_ready) model_accept(pa, pb, pop, pl);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 3'd0, 0, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; a = '0; b = '0; op = '0; last = 0; out_ready = 0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_cnt", y_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;

    // Plain OR beats
    drive(1, 8'h1C, 8'h11, 3'd0, 0, 1);
    drive(1, 8'hB2, 8'hF4, 3'd0, 0, 1);
    idle(2);

    // ACC_OR over three beats
    drive(1, 8'h01, 8'h00, 3'd4, 0, 1);
    drive(1, 8'h02, 8'h00, 3'd4, 0, 1);
    drive(1, 8'h80, 8'h04, 3'd4, 1, 1);
    idle(2);

    // ACC_XOR with op changed mid-transaction
    drive(1, 8'hFF, 8'h0F, 3'd5, 0, 1);
    drive(1, 8'h0F, 8'h00, 3'd1, 1, 1);
    idle(2);

    // Back-pressure: result held while a competing beat is offered
    drive(1, 8'h1C, 8'h11, 3'd0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 8'hAA, 8'h55, 3'd2, 0, 0);
    drive(1, 8'hF0, 8'h0F, 3'd0, 0, 1);
    idle(2);

    // Reset in the middle of an accumulation
    drive(1, 8'h01, 8'h00, 3'd4, 0, 1);
    drive(1, 8'h02, 8'h00, 3'd4, 0, 1);
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0;
    model_reset();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y_cnt", y_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    drive(1, 8'h01, 8'h00, 3'd4, 1, 1);
    idle(2);

    // Count saturation, then illegal ops
    for (int i = 1; i <= 20; i++) drive(1, 8'h00, 8'h00, 3'd4, i == 20, 1);
    drive(1, 8'h5A, 8'hA5, 3'd6, 0, 1);
    drive(1, 8'h5A, 8'hA5, 3'd7, 1, 1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, WIDTH'($urandom), WIDTH'($urandom),
            3'($urandom_range(0, 7)), ($urandom % 4) == 0, ($urandom % 3) != 0);
    end
    idle(4);
    chk("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
